// File: rtl/apb_pkg.sv
// Shared types for the APB requester: queued request record and FSM states.
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wait_cnt;
  } apb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_mst_state_e;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Processor request/response handshake plus APB bus signals of the requester.
interface apb_master_ctrl_if;
  import apb_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [7:0]        req_wait;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wait_cycles;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wait, ready, rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           sel, enable, write, addr, wdata, wait_cycles
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wait, ready, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           sel, enable, write, addr, wdata, wait_cycles
  );

endinterface

// File: rtl/apb_req_fifo.sv
// Request queue: DEPTH-entry circular buffer, head visible combinationally.
module apb_req_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  apb_req_t push_data,
  input  logic     pop,
  output apb_req_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  apb_req_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the flushed pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: drains queued processor requests as SETUP/ACCESS transfers
// and returns one response (read data or timeout error) per request.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  apb_master_ctrl_if.master   bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  apb_mst_state_e    state, state_nxt;
  logic [TMO_W-1:0]  tmo, tmo_nxt;

  logic              sel_q, sel_nxt;
  logic              enable_q, enable_nxt;
  logic              write_q, write_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [7:0]        wait_q, wait_nxt;
  logic              resp_valid_q, resp_valid_nxt;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_nxt;
  logic              resp_err_q, resp_err_nxt;

  apb_req_t          push_data;
  apb_req_t          head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign push_data = '{write: bus.req_write, addr: bus.req_addr,
                       wdata: bus.req_wdata, wait_cnt: bus.req_wait};
  assign bus.req_ready = !reset && !fifo_full;
  assign fifo_push     = bus.req_valid && bus.req_ready;
  assign fifo_pop      = (state == IDLE) && !fifo_empty;

  apb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo          <= '0;
      sel_q        <= 1'b0;
      enable_q     <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmo          <= tmo_nxt;
      sel_q        <= sel_nxt;
      enable_q     <= enable_nxt;
      write_q      <= write_nxt;
      addr_q       <= addr_nxt;
      wdata_q      <= wdata_nxt;
      wait_q       <= wait_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_rdata_q <= resp_rdata_nxt;
      resp_err_q   <= resp_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.ready || (tmo == TMO_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every exit from ACCESS passes through IDLE, so sel is low at least one cycle.
  always_comb begin
    tmo_nxt        = tmo;
    sel_nxt        = sel_q;
    enable_nxt     = enable_q;
    write_nxt      = write_q;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    wait_nxt       = wait_q;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = resp_rdata_q;
    resp_err_nxt   = resp_err_q;
    case (state)
      IDLE: begin
        sel_nxt    = 1'b0;
        enable_nxt = 1'b0;
        if (!fifo_empty) begin
          sel_nxt   = 1'b1;
          write_nxt = head.write;
          addr_nxt  = head.addr;
          wdata_nxt = head.wdata;
          wait_nxt  = head.wait_cnt;
        end
      end
      SETUP: begin
        enable_nxt = 1'b1;
        tmo_nxt    = '0;
      end
      ACCESS: begin
        if (bus.ready) begin
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = write_q ? '0 : bus.rdata;
          resp_err_nxt   = 1'b0;
          sel_nxt        = 1'b0;
          enable_nxt     = 1'b0;
        end else if (tmo == TMO_LAST) begin
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = '0;
          resp_err_nxt   = 1'b1;
          sel_nxt        = 1'b0;
          enable_nxt     = 1'b0;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end
      default: begin
        sel_nxt    = 1'b0;
        enable_nxt = 1'b0;
      end
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.enable      = enable_q;
  assign bus.write       = write_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.wait_cycles = wait_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a wait-state APB slave and memory.
module tb_apb_master_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  apb_master_ctrl_if bus ();

  apb_master_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Slave: ready after wait_cycles ACCESS cycles unless stuck
  logic [7:0] mem [256];
  logic [7:0] wcnt = 8'd0;
  logic       stuck = 1'b0;

  assign bus.ready = bus.sel && bus.enable && !stuck && (wcnt == bus.wait_cycles);
  assign bus.rdata = mem[bus.addr];

  always @(posedge clk) begin
    if (!(bus.sel && bus.enable) || bus.ready) wcnt <= 8'd0;
    else wcnt <= wcnt + 8'd1;
    if (bus.sel && bus.enable && bus.ready && bus.write) mem[bus.addr] <= bus.wdata;
  end

  logic [8:0] resp_q[$];
  int         sel_rises = 0;
  logic       sel_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.resp_valid) resp_q.push_back({bus.resp_err, bus.resp_rdata});
    if (bus.sel && !sel_prev) sel_rises <= sel_rises + 1;
    sel_prev <= bus.sel;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] wt);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("push_ready_timeout", 32'd0, 32'd1);
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wait  = wt;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_sel();
    int n = 0;
    while (!bus.sel && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_sel", 32'(bus.sel), 32'd1);
  endtask

  task automatic wait_resps(input int target);
    int n = 0;
    while (resp_q.size() < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("resp_count", 32'(resp_q.size()), 32'(target));
  endtask

  task automatic check_resp(input string tag, input int idx, input logic [8:0] exp);
    logic [8:0] got;
    got = (idx < resp_q.size()) ? resp_q[idx] : 9'h1FF;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    int base;
    int rbase;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.req_wait  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_enable", 32'(bus.enable), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_ready_after", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // 1: write 0x10=0x5A, wait 0
    push_req(1'b1, 8'h10, 8'h5A, 8'd0);
    check("t1_sel_E0", 32'(bus.sel), 32'd0);
    @(negedge clk);
    check("t1_sel_E1", 32'(bus.sel), 32'd1);
    check("t1_enable_E1", 32'(bus.enable), 32'd0);
    check("t1_addr", 32'(bus.addr), 32'h10);
    check("t1_wdata", 32'(bus.wdata), 32'h5A);
    check("t1_write", 32'(bus.write), 32'd1);
    @(negedge clk);
    check("t1_enable_E2", 32'(bus.enable), 32'd1);
    check("t1_resp_E2", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    check("t1_resp_E3", 32'(bus.resp_valid), 32'd1);
    check("t1_err", 32'(bus.resp_err), 32'd0);
    check("t1_sel_drop", 32'(bus.sel), 32'd0);
    check("t1_mem", 32'(mem[8'h10]), 32'h5A);
    @(negedge clk);
    check("t1_resp_pulse", 32'(bus.resp_valid), 32'd0);

    // 2: read 0x10 with wait 3
    push_req(1'b0, 8'h10, 8'h00, 8'd3);
    repeat (5) @(negedge clk);
    check("t2_resp_E5", 32'(bus.resp_valid), 32'd0);
    check("t2_enable_E5", 32'(bus.enable), 32'd1);
    check("t2_wait_cycles", 32'(bus.wait_cycles), 32'd3);
    @(negedge clk);
    check("t2_resp_E6", 32'(bus.resp_valid), 32'd1);
    check("t2_rdata", 32'(bus.resp_rdata), 32'h5A);
    check("t2_err", 32'(bus.resp_err), 32'd0);
    repeat (2) @(negedge clk);

    // 3: fill the queue behind a long transfer
    base  = resp_q.size();
    rbase = sel_rises;
    push_req(1'b1, 8'h30, 8'h77, 8'd12);
    wait_sel();
    push_req(1'b1, 8'h20, 8'h11, 8'd5);
    push_req(1'b1, 8'h21, 8'h22, 8'd1);
    push_req(1'b0, 8'h20, 8'h00, 8'd0);
    push_req(1'b0, 8'h21, 8'h00, 8'd2);
    check("t3_full_ready", 32'(bus.req_ready), 32'd0);
    check("t3_full_count", 32'(dut.u_fifo.count), 32'd4);
    push_req(1'b1, 8'h22, 8'h33, 8'd0);
    wait_resps(base + 6);
    repeat (3) @(negedge clk);
    check_resp("t3_r0", base + 0, 9'h000);
    check_resp("t3_r1", base + 1, 9'h000);
    check_resp("t3_r2", base + 2, 9'h000);
    check_resp("t3_r3", base + 3, 9'h011);
    check_resp("t3_r4", base + 4, 9'h022);
    check_resp("t3_r5", base + 5, 9'h000);
    check("t3_sel_rises", 32'(sel_rises - rbase), 32'd6);
    check("t3_mem22", 32'(mem[8'h22]), 32'h33);

    // 4: timeout with ready stuck low, next request proceeds
    stuck = 1'b1;
    push_req(1'b0, 8'h10, 8'h00, 8'd0);
    push_req(1'b0, 8'h21, 8'h00, 8'd0);
    repeat (16) @(negedge clk);
    check("t4_resp_early", 32'(bus.resp_valid), 32'd0);
    check("t4_enable_hold", 32'(bus.enable), 32'd1);
    @(negedge clk);
    check("t4_resp", 32'(bus.resp_valid), 32'd1);
    check("t4_err", 32'(bus.resp_err), 32'd1);
    check("t4_rdata", 32'(bus.resp_rdata), 32'd0);
    check("t4_sel_drop", 32'(bus.sel), 32'd0);
    check("t4_enable_drop", 32'(bus.enable), 32'd0);
    stuck = 1'b0;
    @(negedge clk);
    check("t4_next_sel", 32'(bus.sel), 32'd1);
    repeat (2) @(negedge clk);
    check("t4_next_resp", 32'(bus.resp_valid), 32'd1);
    check("t4_next_err", 32'(bus.resp_err), 32'd0);
    check("t4_next_rdata", 32'(bus.resp_rdata), 32'h22);
    repeat (2) @(negedge clk);

    // 5: reset during ACCESS with two queued
    push_req(1'b0, 8'h50, 8'h00, 8'd10);
    wait_sel();
    push_req(1'b0, 8'h10, 8'h00, 8'd0);
    push_req(1'b0, 8'h20, 8'h00, 8'd0);
    check("t5_in_access", 32'(bus.enable), 32'd1);
    base  = resp_q.size();
    rbase = sel_rises;
    reset = 1'b1;
    @(negedge clk);
    check("t5_sel", 32'(bus.sel), 32'd0);
    check("t5_enable", 32'(bus.enable), 32'd0);
    check("t5_req_ready", 32'(bus.req_ready), 32'd0);
    check("t5_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_req_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("t5_no_resp", 32'(resp_q.size()), 32'(base));
    check("t5_no_sel", 32'(sel_rises), 32'(rbase));

    // 6: push and pop on the same edge at count 3
    base = resp_q.size();
    push_req(1'b1, 8'h40, 8'hA1, 8'd8);
    wait_sel();
    push_req(1'b0, 8'h40, 8'h00, 8'd0);
    push_req(1'b1, 8'h41, 8'hB2, 8'd1);
    push_req(1'b0, 8'h41, 8'h00, 8'd0);
    check("t6_count3", 32'(dut.u_fifo.count), 32'd3);
    begin
      int n = 0;
      while (!bus.resp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_first_resp", 32'(bus.resp_valid), 32'd1);
    check("t6_count_pre", 32'(dut.u_fifo.count), 32'd3);
    push_req(1'b0, 8'h40, 8'h00, 8'd2);
    check("t6_count_same", 32'(dut.u_fifo.count), 32'd3);
    check("t6_sel_popped", 32'(bus.sel), 32'd1);
    check("t6_head_addr", 32'(bus.addr), 32'h40);
    wait_resps(base + 5);
    check_resp("t6_r0", base + 0, 9'h000);
    check_resp("t6_r1", base + 1, 9'h0A1);
    check_resp("t6_r2", base + 2, 9'h000);
    check_resp("t6_r3", base + 3, 9'h0B2);
    check_resp("t6_r4", base + 4, 9'h0A1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
